ufi_rect_fill: RTL and testbench



---
 rtl/ufi_rect_fill.sv | 209 ++++++++++++++++++++
 tb/tb_ufi_rect_fill.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ufi_rect_fill.sv
// Rectangle fill engine: a UFI write master that paints one constant colour into a
// rectangular frame-buffer region, with the row-0 offset computed by serial shift-add.
module ufi_rect_fill #(
    parameter int unsigned pBusAdrsBit    = 32,
    parameter int unsigned pUfiBusWidth   = 12,
    parameter int unsigned pHdisplayWidth = 11,
    parameter int unsigned pVdisplayWidth = 11
) (
    input  logic                      iSysClk,
    input  logic                      iSysRst,
    input  logic                      iStart,
    input  logic [pBusAdrsBit-1:0]    iBaseAdrs,
    input  logic [pHdisplayWidth:0]   iStride,
    input  logic [pHdisplayWidth:0]   iX,
    input  logic [pHdisplayWidth:0]   iW,
    input  logic [pVdisplayWidth:0]   iY,
    input  logic [pVdisplayWidth:0]   iH,
    input  logic [pUfiBusWidth-1:0]   iColor,
    input  logic                      iMUfiRdy,
    output logic [pUfiBusWidth-1:0]   oMUfiWd,
    output logic [pBusAdrsBit-1:0]    oMUfiAdrs,
    output logic                      oMUfiWEd,
    output logic                      oMUfiVd,
    output logic                      oMUfiCmd,
    output logic                      oBusy,
    output logic                      oDone
);

    localparam int unsigned lpHW   = pHdisplayWidth + 1;
    localparam int unsigned lpVW   = pVdisplayWidth + 1;
    localparam int unsigned lpCntW = $clog2(lpVW) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_ROW  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              r_state;
    logic [lpCntW-1:0]       r_cnt;
    logic [lpVW-1:0]         r_ysh;
    logic [lpVW-1:0]         r_h;
    logic [lpHW-1:0]         r_stride;
    logic [lpHW-1:0]         r_x;
    logic [lpHW-1:0]         r_we;
    logic [lpHW-1:0]         r_col;
    logic [lpVW-1:0]         r_row;
    logic [pBusAdrsBit-1:0]  r_base;
    logic [pBusAdrsBit-1:0]  r_acc;
    logic [pBusAdrsBit-1:0]  r_row_adrs;
    logic [pUfiBusWidth-1:0] r_color;

    logic [2:0]              w_state_nxt;
    logic [lpCntW-1:0]       w_cnt_nxt;
    logic [lpVW-1:0]         w_ysh_nxt;
    logic [lpHW-1:0]         w_col_nxt;
    logic [lpVW-1:0]         w_row_nxt;
    logic [pBusAdrsBit-1:0]  w_acc_nxt;
    logic [pBusAdrsBit-1:0]  w_row_adrs_nxt;
    logic [pBusAdrsBit-1:0]  w_adrs_nxt;
    logic [pUfiBusWidth-1:0] w_wd_nxt;
    logic                    w_wed_nxt;
    logic                    w_done_nxt;
    logic                    w_start;
    logic [lpHW-1:0]         w_room;
    logic [lpHW-1:0]         w_we_in;
    logic [lpHW-1:0]         w_col_inc;
    logic [lpVW-1:0]         w_row_inc;
    logic [pBusAdrsBit-1:0]  w_acc_step;
    logic [pBusAdrsBit-1:0]  w_row0;
    logic [pBusAdrsBit-1:0]  w_stride_ext;

    // Clipped width and serial multiply datapath (iY consumed MSB first)
    always_comb begin
        w_start      = (r_state == S_IDLE) && iStart;
        w_room       = iStride - iX;
        w_we_in      = (iX >= iStride) ? '0 : ((iW < w_room) ? iW : w_room);
        w_stride_ext = pBusAdrsBit'(r_stride);
        w_acc_step   = (r_acc << 1) + (r_ysh[pVdisplayWidth] ? w_stride_ext : '0);
        w_row0       = r_base + w_acc_step + pBusAdrsBit'(r_x);
        w_col_inc    = r_col + lpHW'(1);
        w_row_inc    = r_row + lpVW'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ysh_nxt      = r_ysh;
        w_acc_nxt      = r_acc;
        w_row_adrs_nxt = r_row_adrs;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_adrs_nxt     = oMUfiAdrs;
        w_wd_nxt       = oMUfiWd;
        w_wed_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_state_nxt = S_CALC;
                    w_cnt_nxt   = '0;
                    w_ysh_nxt   = iY;
                    w_acc_nxt   = '0;
                end
            end
            S_CALC: begin
                w_acc_nxt = w_acc_step;
                w_ysh_nxt = r_ysh << 1;
                w_cnt_nxt = r_cnt + lpCntW'(1);
                if (r_cnt == lpCntW'(pVdisplayWidth)) begin
                    if ((r_we == '0) || (r_h == '0)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = S_ROW;
                        w_row_adrs_nxt = w_row0;
                        w_adrs_nxt     = w_row0;
                        w_wd_nxt       = r_color;
                        w_col_nxt      = '0;
                        w_row_nxt      = '0;
                        w_wed_nxt      = 1'b1;
                    end
                end
            end
            S_ROW: begin
                w_wed_nxt = 1'b1;
                if (oMUfiWEd && iMUfiRdy) begin
                    if (w_col_inc == r_we) begin
                        w_state_nxt = S_GAP;
                        w_wed_nxt   = 1'b0;
                    end else begin
                        w_col_nxt  = w_col_inc;
                        w_adrs_nxt = r_row_adrs + pBusAdrsBit'(w_col_inc);
                    end
                end
            end
            S_GAP: begin
                w_row_adrs_nxt = r_row_adrs + w_stride_ext;
                w_row_nxt      = w_row_inc;
                w_col_nxt      = '0;
                if (w_row_inc == r_h) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_ROW;
                    w_adrs_nxt  = r_row_adrs + w_stride_ext;
                    w_wed_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ysh      <= '0;
            r_h        <= '0;
            r_stride   <= '0;
            r_x        <= '0;
            r_we       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_base     <= '0;
            r_acc      <= '0;
            r_row_adrs <= '0;
            r_color    <= '0;
            oMUfiWd    <= '0;
            oMUfiAdrs  <= '0;
            oMUfiWEd   <= 1'b0;
            oMUfiVd    <= 1'b0;
            oMUfiCmd   <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ysh      <= w_ysh_nxt;
            r_acc      <= w_acc_nxt;
            r_row_adrs <= w_row_adrs_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            if (w_start) begin
                r_h      <= iH;
                r_stride <= iStride;
                r_x      <= iX;
                r_we     <= w_we_in;
                r_base   <= iBaseAdrs;
                r_color  <= iColor;
            end
            oMUfiWd   <= w_wd_nxt;
            oMUfiAdrs <= w_adrs_nxt;
            oMUfiWEd  <= w_wed_nxt;
            oMUfiVd   <= w_wed_nxt;
            oMUfiCmd  <= 1'b0;
            oBusy     <= (w_state_nxt != S_IDLE);
            oDone     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_ufi_rect_fill.sv
// Scoreboard bench for ufi_rect_fill: stimulus pushes expected beats and done latencies,
// a negedge monitor pops and compares whatever the engine presents.
module tb_ufi_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [11:0] stride = '0;
    logic [11:0] x = '0;
    logic [11:0] w = '0;
    logic [11:0] y = '0;
    logic [11:0] h = '0;
    logic [11:0] color = '0;
    logic        rdy = 1'b1;
    logic [11:0] o_wd;
    logic [31:0] o_adrs;
    logic        o_wed;
    logic        o_vd;
    logic        o_cmd;
    logic        o_busy;
    logic        o_done;

    int          cyc = 0;
    int          start_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    int          dones_seen = 0;
    bit          rdy_bp = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_adrs;
    logic [11:0] prev_wd;
    logic [31:0] exp_adrs_q[$];
    logic [11:0] exp_wd_q[$];
    int          exp_done_q[$];

    ufi_rect_fill dut (
        .iSysClk   (clk),
        .iSysRst   (rst),
        .iStart    (start),
        .iBaseAdrs (base),
        .iStride   (stride),
        .iX        (x),
        .iW        (w),
        .iY        (y),
        .iH        (h),
        .iColor    (color),
        .iMUfiRdy  (rdy),
        .oMUfiWd   (o_wd),
        .oMUfiAdrs (o_adrs),
        .oMUfiWEd  (o_wed),
        .oMUfiVd   (o_vd),
        .oMUfiCmd  (o_cmd),
        .oBusy     (o_busy),
        .oDone     (o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic monitor_step();
        int ed;
        if (rst) begin
            prev_stall = 1'b0;
            return;
        end
        if (o_wed || o_vd) chk("vd_follows_wed", 32'(o_vd), 32'(o_wed));
        if (prev_stall && o_wed) begin
            chk("stall_adrs_stable", o_adrs, prev_adrs);
            chk("stall_data_stable", 32'(o_wd), 32'(prev_wd));
        end
        if (o_wed && rdy) begin
            if (exp_adrs_q.size() == 0) begin
                chk("unexpected_beat_adrs", o_adrs, 32'hFFFF_FFFF);
            end else begin
                chk("beat_adrs", o_adrs, exp_adrs_q.pop_front());
                chk("beat_data", 32'(o_wd), 32'(exp_wd_q.pop_front()));
            end
            beats_seen++;
        end
        prev_stall = o_wed && !rdy;
        prev_adrs  = o_adrs;
        prev_wd    = o_wd;
        if (o_done) begin
            if (exp_done_q.size() == 0) begin
                chk("unexpected_done", 32'(o_done), 32'd0);
            end else begin
                ed = exp_done_q.pop_front();
                if (ed >= 0) chk("done_latency", 32'(cyc - start_cyc), 32'(ed));
            end
            dones_seen++;
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (dones_seen < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 32'(dones_seen >= target), 32'd1);
    endtask

    // Issues one fill; the expected beat list comes from the clipped-rectangle formula
    task automatic launch(input logic [31:0] b, input int s, input int xx, input int yy,
                          input int ww, input int hh, input logic [11:0] c,
                          input bit bp, input int exp_done, output int nbeats);
        int we;
        we = (xx >= s) ? 0 : ((ww < s - xx) ? ww : s - xx);
        nbeats = we * hh;
        for (int r = 0; r < hh; r++)
            for (int k = 0; k < we; k++) begin
                exp_adrs_q.push_back(b + 32'((yy + r) * s + xx + k));
                exp_wd_q.push_back(c);
            end
        if (exp_done >= -1) exp_done_q.push_back(exp_done);
        rdy_bp = bp;
        @(posedge clk);
        #1;
        base = b; stride = 12'(s); x = 12'(xx); y = 12'(yy); w = 12'(ww); h = 12'(hh);
        color = c; start = 1'b1; start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_fill(input string name, input logic [31:0] b, input int s, input int xx,
                            input int yy, input int ww, input int hh, input logic [11:0] c,
                            input bit bp, input int exp_done);
        int nb0, nd0, nbeats;
        nb0 = beats_seen;
        nd0 = dones_seen;
        launch(b, s, xx, yy, ww, hh, c, bp, exp_done, nbeats);
        wait_done(nd0 + 1, name);
        repeat (4) @(posedge clk);
        chk({name, "_beats"}, 32'(beats_seen - nb0), 32'(nbeats));
        chk({name, "_left"}, 32'(exp_adrs_q.size()), 32'd0);
        chk({name, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int nb, nd, dummy;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            forever begin
                @(posedge clk);
                #1;
                rdy = !rdy_bp || (cyc % 4 == 0) || (cyc % 4 == 3);
            end
        join_none

        // Reset values
        #1;
        chk("rst_wd", 32'(o_wd), 32'd0);
        chk("rst_adrs", o_adrs, 32'd0);
        chk("rst_wed", 32'(o_wed), 32'd0);
        chk("rst_vd", 32'(o_vd), 32'd0);
        chk("rst_cmd", 32'(o_cmd), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic: 970..973, 1450..1453; done 12 + 2*5 + 1 = 23
        run_fill("basic", 32'd0, 480, 10, 2, 4, 2, 12'hF00, 1'b0, 23);
        // Busy flag one cycle after start on the next fill
        launch(32'd0, 480, 10, 2, 4, 2, 12'hF00, 1'b1, -1, dummy);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        nd = dones_seen;
        wait_done(nd + 1, "backpressure");
        repeat (4) @(posedge clk);
        chk("backpressure_left", 32'(exp_adrs_q.size()), 32'd0);
        rdy_bp = 1'b0;
        // Clipping: 478/479, 958/959, 1438/1439; done 12 + 3*3 + 1 = 22
        run_fill("clip", 32'd0, 480, 478, 0, 5, 3, 12'h0AB, 1'b0, 22);
        // Degenerate fills finish at 13 with no beats
        run_fill("deg_w0", 32'd100, 480, 10, 2, 0, 2, 12'h123, 1'b0, 13);
        run_fill("deg_x500", 32'd100, 480, 500, 2, 4, 2, 12'h123, 1'b0, 13);
        run_fill("deg_h0", 32'd100, 480, 10, 2, 4, 0, 12'h123, 1'b0, 13);
        // Wrapping base address
        run_fill("wrap", 32'hFFFF_FFFE, 16, 1, 0, 3, 1, 12'h555, 1'b0, 17);

        // Second start during ROW is ignored
        nb = beats_seen;
        nd = dones_seen;
        fork
            launch(32'd0, 480, 10, 2, 4, 2, 12'hF00, 1'b0, 23, dummy);
            begin
                repeat (16) @(posedge clk);
                #2;
                start = 1'b1; color = 12'h0F0; x = 12'd0; y = 12'd0;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
        join
        wait_done(nd + 1, "busy_start");
        repeat (40) @(posedge clk);
        chk("busy_start_beats", 32'(beats_seen - nb), 32'd8);
        chk("busy_start_dones", 32'(dones_seen - nd), 32'd1);
        chk("busy_start_left", 32'(exp_adrs_q.size()), 32'd0);

        // Reset after three beats: async clear, no done
        nb = beats_seen;
        nd = dones_seen;
        launch(32'd0, 480, 10, 2, 4, 2, 12'hF00, 1'b0, -2, dummy);
        begin
            int n = 0;
            while (beats_seen < nb + 3 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        chk("rst_mid_three_beats", 32'(beats_seen - nb), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_wed", 32'(o_wed), 32'd0);
        chk("rst_mid_vd", 32'(o_vd), 32'd0);
        chk("rst_mid_adrs", o_adrs, 32'd0);
        chk("rst_mid_wd", 32'(o_wd), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        exp_adrs_q.delete();
        exp_wd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        chk("rst_mid_no_done", 32'(dones_seen - nd), 32'd0);
        run_fill("after_rst", 32'd0, 480, 10, 2, 4, 2, 12'h00F, 1'b0, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
